eth_tx_fcs_insert: RTL and testbench

ETH_TX_FCS_INSERT -- requirements
Module: eth_tx_fcs_insert

---
 rtl/eth_tx_fcs_insert_if.sv | 24 ++
 rtl/eth_tx_fcs_insert.sv | 170 +++++++++++++++++
 tb/tb_eth_tx_fcs_insert.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_fcs_insert_if.sv
// Byte-stream bundle for the Ethernet TX FCS inserter.
// The upstream (s_*) and downstream (m_*) channels are kept together so the port names stay the same.
interface eth_tx_fcs_insert_if;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;

  // Block-side view
  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  // Environment-side view
  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/eth_tx_fcs_insert.sv
// Ethernet TX framer tail: passes the payload through, zero-pads it to the minimum frame
// length, then appends the CRC32 FCS LSB first, all through a single output register.
module eth_tx_fcs_insert #(
  parameter int unsigned MIN_FRAME_LEN  = 60,
  parameter bit          ENABLE_PADDING = 1'b1
) (
  input logic                clk,
  input logic                rst,
  eth_tx_fcs_insert_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS
  } state_e;

  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] CNT_MAX = '1;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tlast_q, m_tlast_d;

  logic        load_ok;
  logic        s_tready_int;
  logic        accept;
  logic [10:0] cnt_inc;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  // Reflected CRC32 (0xEDB88320) contribution of the low nibble after four shifts.
  function automatic logic [31:0] crc_nibble(input logic [3:0] n);
    logic [31:0] r;
    case (n)
      4'h0:    r = 32'h0000_0000;
      4'h1:    r = 32'h1DB7_1064;
      4'h2:    r = 32'h3B6E_20C8;
      4'h3:    r = 32'h26D9_30AC;
      4'h4:    r = 32'h76DC_4190;
      4'h5:    r = 32'h6B6B_51F4;
      4'h6:    r = 32'h4DB2_6158;
      4'h7:    r = 32'h5005_713C;
      4'h8:    r = 32'hEDB8_8320;
      4'h9:    r = 32'hF00F_9344;
      4'hA:    r = 32'hD6D6_A3E8;
      4'hB:    r = 32'hCB61_B38C;
      4'hC:    r = 32'h9B64_C2B0;
      4'hD:    r = 32'h86D3_D2D4;
      4'hE:    r = 32'hA00A_E278;
      default: r = 32'hBDBD_F21C;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h00_0000, d};
    x = (x >> 4) ^ crc_nibble(x[3:0]);
    x = (x >> 4) ^ crc_nibble(x[3:0]);
    return x;
  endfunction

  always_comb begin
    load_ok      = !m_tvalid_q || bus.m_tready;
    s_tready_int = !rst && load_ok && ((state_q == ST_IDLE) || (state_q == ST_PAYLOAD));
    accept       = bus.s_tvalid && s_tready_int;
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 11'd1;
  end

  always_comb begin
    fcs = ~crc_q;
    case (idx_q)
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    idx_d      = idx_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q && !bus.m_tready;

    case (state_q)
      ST_IDLE, ST_PAYLOAD: begin
        if (accept) begin
          m_tdata_d  = bus.s_tdata;
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          crc_d      = crc_byte(crc_q, bus.s_tdata);
          cnt_d      = cnt_inc;
          if (!bus.s_tlast) begin
            state_d = ST_PAYLOAD;
          end else if (ENABLE_PADDING && (cnt_inc < MIN_LEN)) begin
            state_d = ST_PAD;
          end else begin
            state_d = ST_FCS;
          end
        end
      end

      ST_PAD: begin
        if (load_ok) begin
          m_tdata_d  = 8'h00;
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          crc_d      = crc_byte(crc_q, 8'h00);
          cnt_d      = cnt_inc;
          if (cnt_inc >= MIN_LEN) begin
            state_d = ST_FCS;
          end
        end
      end

      ST_FCS: begin
        if (load_ok) begin
          m_tdata_d  = fcs_byte;
          m_tvalid_d = 1'b1;
          m_tlast_d  = (idx_q == 2'd3);
          idx_d      = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
            crc_d   = '1;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      crc_q      <= '1;
      idx_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      idx_q      <= idx_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  assign bus.s_tready = s_tready_int;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tlast  = m_tlast_q;

endmodule

// File: tb/tb_eth_tx_fcs_insert.sv
// Randomised self-checking bench for eth_tx_fcs_insert: a queue-based frame model
// (payload, zero pad, bitwise CRC32, LSB-first FCS) is compared on every output transfer.
module tb_eth_tx_fcs_insert;

  logic       clk;
  logic       rst;
  logic [7:0] drv_data;
  logic       drv_valid;
  logic       drv_last;
  logic       drv_mready;
  logic       sel_pad;

  logic       mon_sready;
  logic [7:0] mon_mdata;
  logic       mon_mvalid;
  logic       mon_mlast;
  logic       mon_mready;

  eth_tx_fcs_insert_if if_p ();
  eth_tx_fcs_insert_if if_np ();

  eth_tx_fcs_insert #(.MIN_FRAME_LEN(60), .ENABLE_PADDING(1'b1)) dut_p (
    .clk (clk),
    .rst (rst),
    .bus (if_p)
  );

  eth_tx_fcs_insert #(.MIN_FRAME_LEN(60), .ENABLE_PADDING(1'b0)) dut_np (
    .clk (clk),
    .rst (rst),
    .bus (if_np)
  );

  // Only the selected instance sees traffic; the other idles with m_tready high.
  assign if_p.s_tdata   = drv_data;
  assign if_p.s_tlast   = drv_last;
  assign if_p.s_tvalid  = drv_valid && sel_pad;
  assign if_p.m_tready  = sel_pad ? drv_mready : 1'b1;
  assign if_np.s_tdata  = drv_data;
  assign if_np.s_tlast  = drv_last;
  assign if_np.s_tvalid = drv_valid && !sel_pad;
  assign if_np.m_tready = sel_pad ? 1'b1 : drv_mready;

  assign mon_sready = sel_pad ? if_p.s_tready : if_np.s_tready;
  assign mon_mdata  = sel_pad ? if_p.m_tdata  : if_np.m_tdata;
  assign mon_mvalid = sel_pad ? if_p.m_tvalid : if_np.m_tvalid;
  assign mon_mlast  = sel_pad ? if_p.m_tlast  : if_np.m_tlast;
  assign mon_mready = drv_mready;

  int         n_checks;
  int         n_pass;
  int         cyc;
  int         mode;
  int         last_acc_cyc;
  int         first_acc_cyc;
  int         first_out_cyc;
  int         first_stall;
  logic [7:0] pl[$];
  logic [7:0] exp_d[$];
  bit         exp_l[$];
  logic [7:0] obs_d[$];
  bit         obs_l[$];
  logic [7:0] ref60[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // m_tready pattern: 0 = always ready, 1 = toggle every cycle, 2 = random
  initial begin
    drv_mready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       drv_mready = 1'b1;
        1:       drv_mready = !drv_mready;
        default: drv_mready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // Expected wire image of the frame currently in pl[]
  task automatic model_push(input bit pad_en);
    logic [31:0] crc;
    int          n;
    crc = 32'hFFFF_FFFF;
    n   = 0;
    foreach (pl[i]) begin
      exp_d.push_back(pl[i]);
      exp_l.push_back(1'b0);
      crc = model_crc(crc, pl[i]);
      n++;
    end
    while (pad_en && n < 60) begin
      exp_d.push_back(8'h00);
      exp_l.push_back(1'b0);
      crc = model_crc(crc, 8'h00);
      n++;
    end
    crc = ~crc;
    for (int k = 0; k < 4; k++) begin
      exp_d.push_back(crc[8*k +: 8]);
      exp_l.push_back(k == 3);
    end
  endtask

  // Output-side scoreboard, sampled on the falling edge
  initial begin
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", {31'b0, mon_mvalid}, 32'd1);
          check("hold_data", {24'b0, mon_mdata}, {24'b0, prev_d});
          check("hold_last", {31'b0, mon_mlast}, {31'b0, prev_l});
        end
        if (mon_mvalid && mon_mready) begin
          if (exp_d.size() == 0) begin
            check("unexpected_out", {24'b0, mon_mdata}, 32'hDEAD);
          end else begin
            check("out_data", {24'b0, mon_mdata}, {24'b0, exp_d.pop_front()});
            check("out_last", {31'b0, mon_mlast}, {31'b0, exp_l.pop_front()});
          end
          if (obs_d.size() == 0) first_out_cyc = cyc;
          obs_d.push_back(mon_mdata);
          obs_l.push_back(mon_mlast);
        end
        prev_stall = mon_mvalid && !mon_mready;
        prev_d     = mon_mdata;
        prev_l     = mon_mlast;
      end
    end
  end

  task automatic drive_byte(input logic [7:0] d, input logic l, output int stalls);
    drv_data  = d;
    drv_last  = l;
    drv_valid = 1'b1;
    stalls    = 0;
    forever begin
      @(negedge clk);
      if (mon_sready) break;
      stalls++;
      if (stalls > 2000) begin
        check("accept_timeout", 32'(stalls), 32'd0);
        break;
      end
    end
    last_acc_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  // Sends pl[]; abort_at > 0 pulses reset right after that many bytes were accepted.
  task automatic send_frame(input bit gaps, input int abort_at);
    int st;
    model_push(sel_pad);
    for (int i = 0; i < pl.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        drv_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      drive_byte(pl[i], i == pl.size() - 1, st);
      if (i == 0) begin
        first_stall   = st;
        first_acc_cyc = last_acc_cyc;
      end
      if (abort_at != 0 && i + 1 == abort_at) begin
        #1;
        rst       = 1'b1;
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        exp_d.delete();
        exp_l.delete();
        return;
      end
    end
    drv_valid = 1'b0;
    drv_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_d.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_d.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill_check_string();
    logic [7:0] s [9];
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    pl.delete();
    foreach (s[i]) pl.push_back(s[i]);
  endtask

  function automatic int count_last();
    int c;
    c = 0;
    foreach (obs_l[i]) if (obs_l[i]) c++;
    return c;
  endfunction

  initial begin
    logic [31:0] crc;
    logic [7:0]  lit [13];
    int          len;

    n_checks  = 0;
    n_pass    = 0;
    mode      = 0;
    rst       = 1'b1;
    sel_pad   = 1'b0;
    drv_data  = '0;
    drv_valid = 1'b0;
    drv_last  = 1'b0;

    // Reset values of both instances
    #3;
    check("rst_p_mvalid", {31'b0, if_p.m_tvalid}, 32'd0);
    check("rst_p_mlast", {31'b0, if_p.m_tlast}, 32'd0);
    check("rst_p_mdata", {24'b0, if_p.m_tdata}, 32'd0);
    check("rst_p_sready", {31'b0, if_p.s_tready}, 32'd0);
    check("rst_np_mvalid", {31'b0, if_np.m_tvalid}, 32'd0);
    check("rst_np_sready", {31'b0, if_np.s_tready}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_sready", {31'b0, mon_sready}, 32'd1);
    @(posedge clk);
    #1;

    // Pin the reference CRC to the well-known check value
    fill_check_string();
    crc = 32'hFFFF_FFFF;
    foreach (pl[i]) crc = model_crc(crc, pl[i]);
    check("model_crc_check", ~crc, 32'hCBF4_3926);

    // "123456789" without padding
    lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    sel_pad = 1'b0;
    obs_d.delete();
    obs_l.delete();
    send_frame(1'b0, 0);
    wait_drain();
    check("str_len", 32'(obs_d.size()), 32'd13);
    if (obs_d.size() == 13) begin
      for (int i = 0; i < 13; i++) check("str_byte", {24'b0, obs_d[i]}, {24'b0, lit[i]});
      check("str_last_pos", {31'b0, obs_l[12]}, 32'd1);
    end
    check("str_tlast_cnt", 32'(count_last()), 32'd1);
    check("str_latency", 32'(first_out_cyc - first_acc_cyc), 32'd1);

    // Single byte, padded to the minimum length
    sel_pad = 1'b1;
    pl.delete();
    pl.push_back(8'hAA);
    obs_d.delete();
    obs_l.delete();
    send_frame(1'b0, 0);
    wait_drain();
    check("pad1_len", 32'(obs_d.size()), 32'd64);
    if (obs_d.size() == 64) begin
      check("pad1_first", {24'b0, obs_d[0]}, 32'hAA);
      check("pad1_pad59", {24'b0, obs_d[59]}, 32'h00);
      check("pad1_last_pos", {31'b0, obs_l[63]}, 32'd1);
    end
    check("pad1_tlast_cnt", 32'(count_last()), 32'd1);

    // Exactly minimum length: no padding
    pl.delete();
    for (int i = 0; i < 60; i++) pl.push_back(8'(i));
    obs_d.delete();
    obs_l.delete();
    send_frame(1'b0, 0);
    wait_drain();
    check("min_len", 32'(obs_d.size()), 32'd64);
    if (obs_d.size() == 64) check("min_byte59", {24'b0, obs_d[59]}, 32'h3B);
    ref60 = obs_d;

    // Same frame with m_tready toggling every cycle
    mode = 1;
    obs_d.delete();
    obs_l.delete();
    send_frame(1'b0, 0);
    wait_drain();
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    check("toggle_len", 32'(obs_d.size()), 32'(ref60.size()));
    if (obs_d.size() == ref60.size())
      foreach (ref60[i]) check("toggle_same", {24'b0, obs_d[i]}, {24'b0, ref60[i]});

    // Reset while byte 20 sits in the output register, then a clean frame
    sel_pad = 1'b0;
    pl.delete();
    for (int i = 0; i < 40; i++) pl.push_back(8'($urandom));
    send_frame(1'b0, 20);
    #1;
    check("async_rst_mvalid", {31'b0, mon_mvalid}, 32'd0);
    check("async_rst_sready", {31'b0, mon_sready}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    fill_check_string();
    obs_d.delete();
    obs_l.delete();
    send_frame(1'b0, 0);
    wait_drain();
    check("rst_frame_len", 32'(obs_d.size()), 32'd13);
    if (obs_d.size() == 13)
      for (int i = 9; i < 13; i++) check("rst_frame_fcs", {24'b0, obs_d[i]}, {24'b0, lit[i]});

    // Back-to-back 64-byte frames, s_tvalid held high
    sel_pad = 1'b1;
    obs_d.delete();
    obs_l.delete();
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'($urandom));
    send_frame(1'b0, 0);
    check("b2b_first_stall", 32'(first_stall), 32'd0);
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'($urandom));
    send_frame(1'b0, 0);
    check("b2b_gap", 32'(first_stall), 32'd4);
    wait_drain();
    check("b2b_len", 32'(obs_d.size()), 32'd136);
    check("b2b_tlast_cnt", 32'(count_last()), 32'd2);

    // Long frame past the counter saturation point
    pl.delete();
    for (int i = 0; i < 2100; i++) pl.push_back(8'($urandom));
    send_frame(1'b0, 0);
    wait_drain();

    // Random lengths, input gaps and output back-pressure on both variants
    mode = 2;
    for (int blk = 0; blk < 4; blk++) begin
      sel_pad = blk[0];
      for (int f = 0; f < 4; f++) begin
        len = $urandom_range(1, 100);
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        send_frame(1'b1, 0);
      end
      wait_drain();
      mode = 0;
      repeat (3) @(posedge clk);
      #1;
      mode = 2;
    end
    mode = 0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
